// File: rtl/radix4_divider_pkg.sv
// Shared constants and helpers for the sequential radix-4 signed divider.
package radix4_divider_pkg;

  localparam int pN         = 16;
  localparam int pNumCycles = (pN + 1) / 2;
  localparam int pCntW      = $clog2(pNumCycles + 1);

  // Quotient reported for a zero divisor (-1 in two's complement)
  localparam logic [pN-1:0] pDivZeroQ = {pN{1'b1}};

  // Iterations needed to retire an n-bit quotient two bits at a time
  function automatic int num_cycles(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/radix4_divider_step.sv
// One radix-4 restoring step: pick the largest digit k in {3,2,1,0} with
// T >= k*|D| and return the reduced partial remainder.
module radix4_div_step #(
  parameter int N = 16
) (
  input  logic [N+1:0] T,
  input  logic [N-1:0] Dm,
  input  logic [N+1:0] D3,
  output logic [1:0]   q2,
  output logic [N-1:0] PRn
);

  logic [N+1:0] d1, d2, sub;

  assign d1 = {2'b00, Dm};
  assign d2 = {1'b0, Dm, 1'b0};

  // Digit select; the remainder always fits N bits since it stays below |D|
  always_comb begin
    q2  = 2'd0;
    sub = '0;
    if (T >= D3) begin
      q2  = 2'd3;
      sub = D3;
    end else if (T >= d2) begin
      q2  = 2'd2;
      sub = d2;
    end else if (T >= d1) begin
      q2  = 2'd1;
      sub = d1;
    end
    PRn = N'(T - sub);
  end

endmodule

// File: rtl/radix4_divider.sv
// Sequential signed radix-4 divider, truncating: Q = A / D, Rem = A % D.
// Works on magnitudes, two quotient bits per cycle, sign-fix at the end.
module radix4_divider
  import radix4_divider_pkg::*;
#(
  parameter int N = pN
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Ld,
  input  logic [N-1:0] A,
  input  logic [N-1:0] D,
  output logic         Busy,
  output logic         Valid,
  output logic [N-1:0] Q,
  output logic [N-1:0] Rem
);

  localparam int K  = num_cycles(N);
  localparam int QW = 2 * K;
  localparam int CW = $clog2(K + 1);

  logic [CW-1:0] cntr;
  logic [QW-1:0] dvd, qmag, qnext;
  logic [N-1:0]  dm, pr, a_mag, d_mag, prn;
  logic [N+1:0]  d3, t;
  logic [1:0]    q2;
  logic          s_a, s_q, dz;

  // |-2^(N-1)| wraps to 2^(N-1), which is exact as an unsigned N-bit value
  assign a_mag = A[N-1] ? -A : A;
  assign d_mag = D[N-1] ? -D : D;

  assign t     = {pr, dvd[QW-1 -: 2]};
  assign qnext = {qmag[QW-3:0], q2};
  assign Busy  = (cntr != '0);

  radix4_div_step #(.N(N)) u_step (
    .T   (t),
    .Dm  (dm),
    .D3  (d3),
    .q2  (q2),
    .PRn (prn)
  );

  // Load / iterate / finish; Ld restarts even mid-operation
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cntr  <= '0;
      dvd   <= '0;
      qmag  <= '0;
      dm    <= '0;
      d3    <= '0;
      pr    <= '0;
      s_a   <= 1'b0;
      s_q   <= 1'b0;
      dz    <= 1'b0;
      Valid <= 1'b0;
      Q     <= '0;
      Rem   <= '0;
    end else if (Ld) begin
      cntr  <= CW'(K);
      dvd   <= QW'(a_mag);
      qmag  <= '0;
      dm    <= d_mag;
      d3    <= {2'b00, d_mag} + {1'b0, d_mag, 1'b0};
      pr    <= '0;
      s_a   <= A[N-1];
      s_q   <= A[N-1] ^ D[N-1];
      dz    <= (D == '0);
      Valid <= 1'b0;
    end else if (Busy) begin
      cntr  <= cntr - CW'(1);
      dvd   <= dvd << 2;
      qmag  <= qnext;
      pr    <= prn;
      Valid <= (cntr == CW'(1));
      if (cntr == CW'(1)) begin
        // zero divisor: digits saturate at 3 so PR ends holding |A|,
        // and the sign-fix below hands back A itself as the remainder
        Q   <= dz ? {N{1'b1}} : (s_q ? -qnext[N-1:0] : qnext[N-1:0]);
        Rem <= s_a ? -prn : prn;
      end
    end else begin
      Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_radix4_divider.sv
// Scoreboard bench for radix4_divider (N=16): driver queues expected
// results with their due cycle, a negedge monitor pops on every Valid.
module tb_radix4_divider;

  localparam int N = 16;

  logic         Clk = 1'b0;
  logic         Rst, Ld, Busy, Valid;
  logic [N-1:0] A, D, Q, Rem;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;
  int   cyc    = 0;

  radix4_divider #(.N(N)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Ld    (Ld),
    .A     (A),
    .D     (D),
    .Busy  (Busy),
    .Valid (Valid),
    .Q     (Q),
    .Rem   (Rem)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Valid must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (!Rst && Valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(Valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q",           32'(Q),   32'(e.q));
        chk("rem",         32'(Rem), 32'(e.r));
        chk("valid_cycle", cyc,      e.due);
      end
    end
  end

  // Called just after a posedge; Ld is taken at the next edge, Valid is
  // visible 8 edges after that, i.e. 9 edges after the current one.
  task automatic issue(input int a, input int d, input logic [N-1:0] eq, input logic [N-1:0] er);
    int last;
    last = sb.size() - 1;
    if (sb.size() > 0 && sb[last].due > cyc) void'(sb.pop_back());
    A  = a[N-1:0];
    D  = d[N-1:0];
    Ld = 1'b1;
    sb.push_back('{eq, er, cyc + 9});
    @(posedge Clk); #1;
    Ld = 1'b0;
  endtask

  task automatic issue_ref(input int a, input int d);
    int q, r;
    q = a / d;
    r = a % d;
    issue(a, d, q[N-1:0], r[N-1:0]);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(negedge Clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge Clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!Valid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!Valid) chk("valid_timeout", 32'(Valid), 32'd1);
  endtask

  initial begin
    int a, d;
    Rst = 1'b1; Ld = 1'b0; A = '0; D = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy",  32'(Busy),  32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_q",     32'(Q),     32'd0);
    chk("rst_rem",   32'(Rem),   32'd0);
    Ld = 1'b1; A = 16'd9; D = 16'd2;   // Rst must win over Ld
    @(posedge Clk); #1;
    chk("rst_over_ld", 32'(Busy), 32'd0);
    Rst = 1'b0; Ld = 1'b0;
    @(posedge Clk); #1;

    // Directed vectors, one at a time
    issue(100, 7, 16'd14, 16'd2);
    chk("busy_after_ld", 32'(Busy), 32'd1);
    drain();
    issue(-100, 7,      16'hFFF2, 16'hFFFE);
    drain();
    issue(100, -7,      16'hFFF2, 16'd2);
    drain();
    issue(-32768, -1,   16'h8000, 16'd0);
    drain();
    issue(32767, 1,     16'h7FFF, 16'd0);
    drain();
    issue(1234, 0,      16'hFFFF, 16'd1234);
    drain();
    issue(-7, 2,        16'hFFFD, 16'hFFFF);
    drain();
    issue(5, 10,        16'd0,    16'd5);
    drain();
    issue(-32768, 3,    16'hD556, 16'hFFFE);
    drain();

    // Outputs hold while idle
    repeat (4) @(posedge Clk);
    #1;
    chk("hold_q",   32'(Q),   32'hD556);
    chk("hold_rem", 32'(Rem), 32'hFFFE);
    chk("idle_busy", 32'(Busy), 32'd0);

    // Restart while busy: only the second op completes
    issue(1000, 3, 16'd333, 16'd1);
    repeat (2) @(posedge Clk);
    #1;
    issue(50, 5, 16'd10, 16'd0);
    drain();

    // Reset in the middle of an op
    issue(200, 9, 16'd22, 16'd2);
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    sb.delete();
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_q",    32'(Q),    32'd0);
    chk("midrst_rem",  32'(Rem),  32'd0);
    repeat (12) @(posedge Clk);
    #1;
    chk("midrst_q_later",   32'(Q),   32'd0);
    chk("midrst_rem_later", 32'(Rem), 32'd0);

    // Random pairs, each new Ld issued in the previous op's Valid cycle
    for (int i = 0; i < 300; i++) begin
      a = $signed(16'($urandom()));
      if (i % 2 == 0) begin
        d = int'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) d = -d;
      end else begin
        d = 0;
        while (d == 0) d = $signed(16'($urandom()));
      end
      if (i > 0) wait_valid();
      issue_ref(a, d);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
